// File: rtl/hilo_muldiv.sv
// Execute-stage HI/LO unit: architectural HI/LO, MTHI/MTLO writes, forwarded
// MFHI/MFLO data and a multi-cycle MULT/MULTU/DIV/DIVU engine with busy/done.
module hilo_muldiv #(
    parameter int WIDTH    = 32,
    parameter int DIV_ITER = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             hilo_write,
    input  logic             hi_sel,
    input  logic [WIDTH-1:0] wdata,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             md_cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_rdata,
    output logic [WIDTH-1:0] lo_rdata
);

    localparam int CW = $clog2(DIV_ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sgn_q, sgn_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               dz_q, dz_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               done_q, done_d;

    // prod_q doubles as the divider's {remainder, quotient} shift pair.
    logic [2*WIDTH-1:0] a_ext, b_ext, mul_full;
    logic [WIDTH:0]     rem_sh, diff;
    logic [WIDTH-1:0]   abs_a, abs_b, q_mag, r_mag, q_fix, r_fix;
    logic               op_signed, start_ok;

    assign op_signed = ~md_op[0];
    assign start_ok  = md_start & ~md_cancel;

    assign abs_a = (op_signed & src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
    assign abs_b = (op_signed & src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;

    assign a_ext    = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    assign b_ext    = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    assign mul_full = a_ext * b_ext;

    assign rem_sh = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, b_q};

    assign q_mag = prod_q[WIDTH-1:0];
    assign r_mag = prod_q[2*WIDTH-1:WIDTH];
    assign q_fix = negq_q ? (~q_mag + 1'b1) : q_mag;
    assign r_fix = negr_q ? (~r_mag + 1'b1) : r_mag;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A flushed start also kills a write issued alongside it.
                if (hilo_write && !(md_start && md_cancel)) begin
                    if (hi_sel) hi_d = wdata;
                    else        lo_d = wdata;
                end
                if (start_ok) begin
                    a_d   = src_a;
                    sgn_d = op_signed;
                    cnt_d = '0;
                    if (!md_op[1]) begin
                        state_d = S_MUL;
                        b_d     = src_b;
                    end else begin
                        state_d = S_DIV;
                        b_d     = abs_b;
                        prod_d  = {{WIDTH{1'b0}}, abs_a};
                        negq_d  = op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        negr_d  = op_signed & src_a[WIDTH-1];
                        dz_d    = (src_b == '0);
                    end
                end
            end
            S_MUL: begin
                if (md_cancel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    prod_d = mul_full;
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    hi_d    = prod_q[2*WIDTH-1:WIDTH];
                    lo_d    = prod_q[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                if (md_cancel) begin
                    state_d = S_IDLE;
                end else if (cnt_q != CW'(DIV_ITER)) begin
                    prod_d[WIDTH-1:0]       = {prod_q[WIDTH-2:0], ~diff[WIDTH]};
                    prod_d[2*WIDTH-1:WIDTH] = diff[WIDTH] ? rem_sh[WIDTH-1:0]
                                                          : diff[WIDTH-1:0];
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    // Zero divisor bypasses sign fix: LO all ones, HI = dividend.
                    hi_d    = dz_q ? a_q : r_fix;
                    lo_d    = dz_q ? {WIDTH{1'b1}} : q_fix;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign hi_rdata = (hilo_write &  hi_sel & ~busy) ? wdata : hi_q;
    assign lo_rdata = (hilo_write & ~hi_sel & ~busy) ? wdata : lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized + directed bench for hilo_muldiv against an arithmetic HI/LO model.
module tb_hilo_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0, resetn = 1'b0;
    logic         hilo_write = 1'b0, hi_sel = 1'b0, md_start = 1'b0, md_cancel = 1'b0;
    logic [1:0]   md_op = 2'b00;
    logic [W-1:0] wdata = '0, src_a = '0, src_b = '0;
    logic         busy, done;
    logic [W-1:0] hi_out, lo_out, hi_rdata, lo_rdata;

    hilo_muldiv #(.WIDTH(W), .DIV_ITER(W)) dut (
        .clk(clk), .resetn(resetn), .hilo_write(hilo_write), .hi_sel(hi_sel),
        .wdata(wdata), .md_start(md_start), .md_op(md_op), .src_a(src_a),
        .src_b(src_b), .md_cancel(md_cancel), .busy(busy), .done(done),
        .hi_out(hi_out), .lo_out(lo_out), .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [W-1:0] hi_m = '0, lo_m = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {HI, LO} from plain signed/unsigned 64-bit arithmetic.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, ua, ub, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (op)
            2'd0: p = sa * sb;
            2'd1: p = ua * ub;
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    if (op == 2'd2) begin q = sa / sb; r = sa % sb; end
                    else            begin q = ua / ub; r = ua % ub; end
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    task automatic mt(input logic hs, input logic [W-1:0] v);
        hilo_write = 1'b1; hi_sel = hs; wdata = v;
        #1;
        if (hs) chk("fwd_hi", hi_rdata, v);
        else    chk("fwd_lo", lo_rdata, v);
        chk("fwd_other", hs ? lo_rdata : hi_rdata, hs ? lo_m : hi_m);
        tick();
        hilo_write = 1'b0;
        if (hs) hi_m = v; else lo_m = v;
        chk("mt_hi", hi_out, hi_m);
        chk("mt_lo", lo_out, lo_m);
    endtask

    task automatic md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [63:0] exp, input bit poke);
        int n;
        md_op = op; src_a = a; src_b = b; md_start = 1'b1;
        #1;
        chk("busy_pre", busy, 0);
        tick();
        md_start = 1'b0;
        src_a = $urandom; src_b = $urandom;
        n = 0;
        while (busy && n < 100) begin
            md_start = (poke && n == 1);
            tick();
            n++;
        end
        md_start = 1'b0;
        chk($sformatf("cycles op%0d", op), n, op[1] ? 33 : 2);
        chk("done", done, 1);
        hi_m = exp[63:32]; lo_m = exp[31:0];
        chk($sformatf("hi op%0d a=%h b=%h", op, a, b), hi_out, hi_m);
        chk($sformatf("lo op%0d a=%h b=%h", op, a, b), lo_out, lo_m);
        chk("rdata_hi", hi_rdata, hi_m);
        tick();
        chk("done_off", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        logic [1:0]   op;
        logic [W-1:0] a, b;
        #2;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_hi", hi_out, 0); chk("rst_lo", lo_out, 0);
        #10 resetn = 1'b1;
        tick();

        mt(1'b1, 32'h1234_5678);
        mt(1'b0, 32'h9ABC_DEF0);

        md(2'd0, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 0);
        md(2'd1, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 0);
        md(2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        md(2'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0);
        md(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
        md(2'd3, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 0);
        md(2'd2, 32'hFFFF_FFF0, 32'd0, 64'hFFFF_FFF0_FFFF_FFFF, 0);
        md(2'd3, 32'd1000, 32'd10, 64'h0000_0000_0000_0064, 1);

        // Cancel mid-divide.
        md_op = 2'd2; src_a = 32'd100; src_b = 32'd3; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        repeat (10) tick();
        chk("cancel_busy_before", busy, 1);
        md_cancel = 1'b1;
        tick();
        md_cancel = 1'b0;
        chk("cancel_busy", busy, 0); chk("cancel_done", done, 0);
        chk("cancel_hi", hi_out, hi_m); chk("cancel_lo", lo_out, lo_m);
        tick();
        chk("cancel_done2", done, 0);
        chk("cancel_lo2", lo_out, lo_m);

        // Cancel together with start and a write in IDLE.
        hilo_write = 1'b1; hi_sel = 1'b1; wdata = 32'h0000_1234;
        md_start = 1'b1; md_cancel = 1'b1; md_op = 2'd0;
        tick();
        hilo_write = 1'b0; md_start = 1'b0; md_cancel = 1'b0;
        chk("cstart_busy", busy, 0); chk("cstart_hi", hi_out, hi_m);

        // Async reset mid-divide.
        md_op = 2'd3; src_a = 32'd77; src_b = 32'd5; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        repeat (20) tick();
        #2 resetn = 1'b0;
        #1;
        hi_m = '0; lo_m = '0;
        chk("arst_busy", busy, 0); chk("arst_done", done, 0);
        chk("arst_hi", hi_out, 0); chk("arst_lo", lo_out, 0);
        #1 resetn = 1'b1;
        tick();
        tick();
        chk("arst_done2", done, 0);

        // Write and MULTU start in the same IDLE cycle.
        mt(1'b1, 32'hDEAD_BEEF);
        hilo_write = 1'b1; hi_sel = 1'b0; wdata = 32'h0000_AAAA;
        md_start = 1'b1; md_op = 2'd1; src_a = 32'd2; src_b = 32'd3;
        tick();
        hilo_write = 1'b0; md_start = 1'b0;
        chk("same_lo_e0", lo_out, 32'h0000_AAAA);
        chk("same_busy", busy, 1);
        chk("same_lo_fwd_busy", lo_rdata, 32'h0000_AAAA);
        tick(); tick();
        hi_m = 32'd0; lo_m = 32'd6;
        chk("same_done", done, 1);
        chk("same_hi", hi_out, hi_m); chk("same_lo", lo_out, lo_m);
        tick();

        for (int i = 0; i < 25; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 7) == 0)      b = '0;
            else if ($urandom_range(0, 1) == 1) b = $urandom;
            else                                b = $urandom_range(1, 20);
            if ($urandom_range(0, 3) == 0) mt(1'($urandom_range(0, 1)), $urandom);
            md(op, a, b, ref_md(op, a, b), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Execute-stage HI/LO unit: the consumer side of the decoder's hilo_write control.
- Holds the architectural HI and LO registers.
- Accepts MTHI/MTLO writes.
- Runs multi-cycle MULT/MULTU/DIV/DIVU with a start/busy/done handshake, and supplies forwarded HI/LO read data for MFHI/MFLO.
- Datapath asserts stall while busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- DIV_ITER, 32, restoring-divide iterations; must equal WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- resetn  input  1  asynchronous active-low reset
- hilo_write  input  1  MTHI/MTLO write enable from decoder
- hi_sel  input  1  1 = write HI (MTHI), 0 = write LO (MTLO)
- wdata  input  WIDTH  rs value for MTHI/MTLO
- md_start  input  1  request mul/div, sampled only in IDLE
- md_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  input  WIDTH  rs operand (dividend / multiplicand)
- src_b  input  WIDTH  rt operand (divisor / multiplier)
- md_cancel  input  1  flush (exception/branch kill), aborts operation
- busy  output  1  operation in flight, stall request
- done  output  1  one-cycle pulse, HI/LO updated by mul/div
- hi_out  output  WIDTH  architectural HI register
- lo_out  output  WIDTH  architectural LO register
- hi_rdata  output  WIDTH  forwarded HI for MFHI
- lo_rdata  output  WIDTH  forwarded LO for MFLO

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; HI = LO = 0; busy = 0; done = 0; internal counter/partials = 0.
- Reset asserted mid-operation aborts immediately; no HI/LO update.
- States: IDLE, MUL, DIV.
- IDLE to MUL: md_start=1, md_op[1]=0, md_cancel=0 at edge E0.
  - Operands latched at E0.
  - 64-bit product registered at E1; signed for MULT, zero-extended for MULTU.
  - HI = product[63:32], LO = product[31:0] written at E2.
  - State returns to IDLE at E2.
- IDLE to DIV: md_start=1, md_op[1]=1, md_cancel=0 at edge E0.
  - Operands latched as magnitudes; signs recorded for DIV.
  - Edges E1..E32: one restoring step each; counter counts 0..31.
  - At E33: LO = quotient, HI = remainder, sign-corrected; state IDLE.
- busy: 1 from after E0 until the commit edge (E2 for mul, E33 for div); 0 otherwise. Never asserted combinationally from md_start.
- done: high for exactly one cycle after the commit edge, i.e. the first cycle in which the new HI/LO is visible.
- Signed divide:
  - quotient negative iff src_a[31] != src_b[31];
  - remainder takes the sign of src_a;
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Divide by zero (src_b = 0): still takes 33 cycles.
  - Unsigned: LO = 0xFFFFFFFF, HI = src_a.
  - Signed: LO = 0xFFFFFFFF, HI = src_a.
- MTHI/MTLO: when hilo_write=1 in IDLE, HI (hi_sel=1) or LO (hi_sel=0) = wdata at that edge.
- hilo_write while busy: ignored; the pipeline is stalled by busy and must hold the instruction.
- hilo_write and md_start in the same IDLE cycle: the write is applied at E0; the mul/div commit later overwrites both HI and LO.
- md_start while busy: ignored; no queueing.
- md_cancel:
  - In MUL/DIV: state returns to IDLE at the next edge; HI/LO untouched; done not asserted.
  - Together with md_start in IDLE: start ignored; a concurrent hilo_write is also suppressed.
- Forwarding (combinational):
  - hi_rdata = wdata if hilo_write & hi_sel & ~busy, else HI.
  - lo_rdata = wdata if hilo_write & ~hi_sel & ~busy, else LO.
  - This covers MFHI directly following MTHI.
- hi_out/lo_out are always the registered values.

Test Plan:
- Reset, then MTHI wdata=0x12345678, then MTLO 0x9ABCDEF0 → hi_out=0x12345678, lo_out=0x9ABCDEF0; hi_rdata equals wdata during the write cycle.
- MULT src_a=0xFFFFFFFE (−2), src_b=3 → busy for 2 cycles, done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV src_a=0xFFFFFFF9 (−7), src_b=2 → busy 33 cycles, HI=0xFFFFFFFF (−1), LO=0xFFFFFFFD (−3). DIVU 100/7 → HI=2, LO=14.
- Boundaries:
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
  - md_start during busy → ignored; cycle count unchanged.
- md_cancel at iteration 10 of DIV → IDLE next edge, HI/LO unchanged, no done.
- Async resetn low at iteration 20 → immediately busy=0, HI=LO=0.
- Same-cycle hilo_write (LO=0xAAAA) + MULTU 2×3 → LO=0xAAAA after E0, then HI=0, LO=6 at E2.
